// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide sequencer: shift-add multiplier and restoring
// divider on magnitudes, one bit per cycle, with sign fix-up and a one-cycle write strobe.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             hi_w,
    output logic             lo_w,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;
    state_t state, state_nx;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               sign_q, sign_r, dz_q;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     msum, rsh, dif;
    logic [2*WIDTH-1:0] mul_nx, div_nx, prod_f;
    logic [WIDTH-1:0]   quot_f, rem_f, res_hi, res_lo;

    assign is_signed = ~op_q[0];
    assign mag_a = (is_signed & a_q[WIDTH-1]) ? -a_q : a_q;
    assign mag_b = (is_signed & b_q[WIDTH-1]) ? -b_q : b_q;

    // multiply: add multiplicand into the upper half when the LSB is set, then shift right
    assign msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nx = {msum, acc[WIDTH-1:1]};

    // divide: shift the next dividend bit into the remainder and try a subtract
    assign rsh    = acc[2*WIDTH-1:WIDTH-1];
    assign dif    = rsh - {1'b0, opnd};
    assign div_nx = dif[WIDTH] ? {rsh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {dif[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_f = sign_q ? -acc : acc;
    assign quot_f = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_f  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign res_hi = dz_q ? a_q : (op_q[1] ? rem_f : prod_f[2*WIDTH-1:WIDTH]);
    assign res_lo = dz_q ? '1  : (op_q[1] ? quot_f : prod_f[WIDTH-1:0]);

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !cancel) begin
                    state_nx = S_PREP;
                    stall    = 1'b1;
                end
            end
            S_PREP: begin
                stall    = 1'b1;
                state_nx = cancel ? S_IDLE : S_CALC;
            end
            S_CALC: begin
                stall = 1'b1;
                if (cancel)                state_nx = S_IDLE;
                else if (cnt == CW'(1))    state_nx = S_FIX;
            end
            S_FIX: begin
                stall    = 1'b1;
                state_nx = cancel ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign hi_w = done;
    assign lo_w = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            opnd   <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz_q   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            dz     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (start && !cancel) begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                end
                S_PREP: begin
                    sign_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    sign_r <= is_signed & a_q[WIDTH-1];
                    dz_q   <= op_q[1] & (b_q == '0);
                    cnt    <= CW'(WIDTH);
                    opnd   <= op_q[1] ? mag_b : mag_a;
                    acc    <= {{WIDTH{1'b0}}, (op_q[1] ? mag_a : mag_b)};
                end
                S_CALC: begin
                    acc <= op_q[1] ? div_nx : mul_nx;
                    cnt <= cnt - CW'(1);
                end
                // results become visible only when the write actually happens
                S_FIX: if (!cancel) begin
                    hi <= res_hi;
                    lo <= res_lo;
                    dz <= dz_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against a plain-arithmetic
// HI/LO model; covers latency, strobes, divide-by-zero, cancel and async reset.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, cancel = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         stall, busy, done, hi_w, lo_w, dz;
    logic [W-1:0] hi, lo;

    int checks = 0, failures = 0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;
    logic         exp_dz = 1'b0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .stall(stall), .busy(busy), .done(done),
        .hi_w(hi_w), .lo_w(lo_w), .hi(hi), .lo(lo), .dz(dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    // {dz, hi, lo} from MIPS HI/LO semantics
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sp, sq, sr;
        logic [63:0] up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'd0: begin sp = sx * sy; return {1'b0, sp}; end
            2'd1: begin up = {32'd0, x} * {32'd0, y}; return {1'b0, up}; end
            2'd2: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                sq = sx / sy;
                sr = sx % sy;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // call #1 after a rising edge with the sequencer idle
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit noise);
        logic [64:0] m;
        int cyc;
        bit bad;
        m = model(o, x, y);
        op = o; a = x; b = y; start = 1'b1;
        #1 chk("stall_issue", 64'(stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        bad = 1'b0;
        while (!done && cyc < 60) begin
            if (!stall || !busy) bad = 1'b1;
            if (noise) begin
                start = 1'($urandom); op = 2'($urandom); a = $urandom; b = $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("latency", 64'(cyc), 64'(W + 2));
        chk("stall_run", 64'(bad), 64'd0);
        chk("done_stall_busy", {62'd0, stall, busy}, 64'd1);
        chk("strobes", {62'd0, hi_w, lo_w}, 64'd3);
        chk("hi", 64'(hi), 64'(m[63:32]));
        chk("lo", 64'(lo), 64'(m[31:0]));
        chk("dz", 64'(dz), 64'(m[64]));
        exp_hi = m[63:32]; exp_lo = m[31:0]; exp_dz = m[64];
        if (noise) begin start = 1'b1; cancel = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        chk("done_pulse", {60'd0, done, hi_w, lo_w, busy}, 64'd0);
        chk("hold", {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit seen;
        #1 chk("reset_out", {stall, busy, done, hi_w, lo_w, dz, hi, lo}, 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("t1_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        chk("t2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        chk("t3_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 0);
        chk("t3_divu", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
        run_op(2'd3, 32'd5, 32'd0, 0);
        chk("t4_dz", {31'd0, dz, hi}, 64'h1_0000_0005);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("t4_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op(2'd2, 32'h8000_0007, 32'd0, 0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(2'($urandom), ra, rb, 1);
        end

        // start and cancel together in IDLE: cancel wins
        start = 1'b1; cancel = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
        #1 chk("sc_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        chk("sc_busy", 64'(busy), 64'd0);

        // cancel in CALC cycle 10
        op = 2'd1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || hi_w || lo_w || busy) seen = 1'b1;
        end
        chk("cancel_nowrite", 64'(seen), 64'd0);
        chk("cancel_hold", {31'd0, dz, hi, lo} , {31'd0, exp_dz, exp_hi, exp_lo});

        // async reset mid-CALC
        op = 2'd2; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid", {stall, busy, done, hi_w, lo_w, dz, hi, lo}, 64'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(2'd0, 32'd6, 32'd7, 0);
        chk("rst_after", {hi, lo}, 64'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
